spi_port_arbiter: RTL and testbench
===================================

// Module: spi_port_arbiter
// PURPOSE
//  Shares one chameleon2_spi byte engine between CHANNELS requesters (ch0 = flash loader,
//  ch1 = mmc64). Replaces the static rom_load_done mux in the top level.
//  Uses toggle req/ack on both sides. Provides round-robin grant, a per-channel hold lock
//  that keeps multi-byte frames atomic, and a stuck-engine watchdog.
// PARAMETERS
//  CHANNELS        2      number of requesters (2..8)
//  TIMEOUT_CYCLES  65535  clk cycles a byte may take before the watchdog fires (<2^20)
// PORTS
//  clk          in   1     system clock; single clock domain
//  reset_n      in   1     reset, asynchronous, active-low
//  req          in   CH    per-channel request toggle; pending[i] = req[i] ^ ack[i]
//  ack          out  CH    per-channel ack toggle; becomes equal to req[i] when its byte is done
//  hold         in   CH    channel keeps ownership after its byte while high
//  d            in   8*CH  tx byte, ch i at [8i+7:8i]; sampled at grant
//  speed        in   CH    per-channel SPI speed select; sampled at grant
//  q            out  8*CH  per-channel rx byte; valid from the cycle ack[i] toggles until the next completion
//  spi_req      out  1     toggle toward the SPI engine
//  spi_ack      in   1     toggle from the SPI engine
//  spi_d        out  8     tx byte to the engine, registered
//  spi_speed    out  1     speed to the engine, registered
//  spi_q        in   8     rx byte from the engine
//  owner        out  3     index of the last or current granted channel
//  busy         out  1     high in WAIT
//  timeout_err  out  1     sticky; set by the watchdog
//  err_clr      in   1     single-cycle pulse that clears timeout_err
// BEHAVIOUR
//  Reset values: ack=0, q=0, spi_req=0, spi_d=0, spi_speed=0, owner=0, busy=0,
//   timeout_err=0, rr_ptr=0, state=RESYNC.
//  FSM:
//   RESYNC: spi_req <= spi_ack. Next state IDLE. This absorbs an engine left mid-toggle by reset.
//   IDLE: eligible = pending & (hold[owner] ? onehot(owner) : all-ones).
//    - If eligible != 0: g = first eligible at or after rr_ptr (wrapping).
//      spi_d <= d[g], spi_speed <= speed[g], owner <= g, spi_req toggles.
//      Next state WAIT. Timer clears.
//    - Otherwise stay in IDLE.
//   WAIT: busy=1; timer increments each cycle.
//    - On spi_req == spi_ack: q[g] <= spi_q, ack[g] toggles, rr_ptr <= g+1 mod CH.
//      Next state IDLE.
//    - On timer == TIMEOUT_CYCLES-1 (before an ack): q[g] <= 8'hFF, ack[g] toggles,
//      timeout_err <= 1, spi_req <= spi_ack (resync). Next state IDLE.
//  Latency: req toggle at cycle t -> spi_req toggles at t+1 when IDLE and eligible.
//   Engine ack at cycle u -> ack[g] toggles at u+1. Minimum gap between two grants is 1 IDLE cycle.
//  Lock:
//   - hold[owner] high blocks all other channels, even when owner has no pending request.
//   - hold on a non-owner channel is ignored.
//   - Dropping hold releases the lock next IDLE cycle; round robin resumes from rr_ptr.
//  Simultaneous events:
//   - New req toggles on several channels in the same cycle: round robin resolves them.
//   - err_clr in the same cycle as a new timeout: the set wins.
//   - Once granted, req/d changes by the granted channel are ignored until its ack.
//     The protocol forbids re-toggling before ack.
//  Async reset mid-byte: all registers go to reset values immediately.
//   Requesters must be reset by the same reset_n. RESYNC then realigns with the engine.
//  Width: rr_ptr and owner are $clog2(CH) bits, zero-extended onto the 3-bit owner port.
//   Timer is 20 bits.
// STRUCTURE
//  spi_arb_defs.vh: state encodings (RESYNC/IDLE/WAIT) and the default timeout localparam.
//  Sub-module rr_picker (combinational): inputs eligible mask and rr_ptr; outputs grant
//   index and any.
//  Everything else (FSM, registers, watchdog) lives in spi_port_arbiter.
// TESTING
//  Bench provides a behavioural engine model with a configurable byte delay N (default 4).
//  1. Post-reset, engine spi_ack=1: RESYNC drives spi_req=1, no spurious ack. Then ch0 d=8'h9F
//     -> spi_d=8'h9F one cycle after the toggle; ack[0] toggles; q[7:0]=model rx byte 8'hA5.
//  2. ch0 and ch1 toggle req in the same cycle, rr_ptr=0 -> ch0 served first, ch1 next.
//     Repeat with rr_ptr=1 -> ch1 first.
//  3. ch1 hold=1 for a 6-byte frame with ch0 pending throughout -> all 6 ch1 bytes go back to back.
//     ch0 is granted on the first IDLE after hold drops.
//  4. TIMEOUT_CYCLES=16, engine never acks -> at WAIT cycle 16: ack toggles, q=8'hFF,
//     timeout_err=1. A next byte with a working engine completes normally.
//     err_clr clears timeout_err.
//  5. reset_n pulsed low mid-WAIT -> all outputs 0 asynchronously. Engine left with
//     spi_ack != spi_req; after release, RESYNC aligns them and ch0 completes a byte.
//  6. speed[1]=1, speed[0]=0, alternating bytes -> spi_speed matches the granted channel
//     for every byte.

Source files
------------

// File: rtl/spi_port_arbiter_pkg.sv
// rtl/spi_port_arbiter_pkg.sv - shared types and constants for the SPI port arbiter
package spi_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 65535;
  localparam int TIMER_W         = 20;
  localparam int OWNER_PORT_W    = 3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_port_arbiter_rr_picker.sv
// rtl/spi_port_arbiter_rr_picker.sv - combinational round-robin picker
// Returns the first eligible index at or after ptr, wrapping around N channels.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest eligible index wins last.
  always_comb begin
    grant = '0;
    any   = |eligible;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[wrap_idx(ptr, k)]) grant = wrap_idx(ptr, k);
    end
  end

endmodule

// File: rtl/spi_port_arbiter.sv
// rtl/spi_port_arbiter.sv - shares one toggle-handshake SPI byte engine between channels
// Round-robin grant, owner hold lock for atomic frames, and a stuck-engine watchdog.
module spi_port_arbiter
  import spi_port_arbiter_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       req,
  output logic [CHANNELS-1:0]       ack,
  input  logic [CHANNELS-1:0]       hold,
  input  logic [8*CHANNELS-1:0]     d,
  input  logic [CHANNELS-1:0]       speed,
  output logic [8*CHANNELS-1:0]     q,
  output logic                      spi_req,
  input  logic                      spi_ack,
  output logic [7:0]                spi_d,
  output logic                      spi_speed,
  input  logic [7:0]                spi_q,
  output logic [OWNER_PORT_W-1:0]   owner,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  localparam int IW = idx_width(CHANNELS);

  state_t              state, state_next;
  logic [IW-1:0]       rr_ptr, owner_r, next_ptr, grant;
  logic [TIMER_W-1:0]  timer;
  logic [CHANNELS-1:0] pending, lock_mask, eligible;
  logic                any, engine_done, expired;
  logic                do_grant, do_done, do_expire;

  assign pending     = req ^ ack;
  // A held owner masks every other channel, even while it has nothing pending.
  assign lock_mask   = hold[owner_r] ? (CHANNELS'(1) << owner_r) : '1;
  assign eligible    = pending & lock_mask;
  assign engine_done = (spi_req == spi_ack);
  assign expired     = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign next_ptr    = (owner_r == IW'(CHANNELS - 1)) ? '0 : owner_r + 1'b1;
  assign owner       = OWNER_PORT_W'(owner_r);

  rr_picker #(
    .N (CHANNELS),
    .W (IW)
  ) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .any      (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RESYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESYNC: state_next = ST_IDLE;
      ST_IDLE:   if (any) state_next = ST_WAIT;
      ST_WAIT:   if (engine_done || expired) state_next = ST_IDLE;
      default:   state_next = ST_RESYNC;
    endcase
  end

  always_comb begin
    busy      = (state == ST_WAIT);
    do_grant  = (state == ST_IDLE) && any;
    do_done   = (state == ST_WAIT) && engine_done;
    do_expire = (state == ST_WAIT) && !engine_done && expired;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack         <= '0;
      q           <= '0;
      spi_req     <= 1'b0;
      spi_d       <= 8'h00;
      spi_speed   <= 1'b0;
      owner_r     <= '0;
      rr_ptr      <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_RESYNC) spi_req <= spi_ack;

      if (state == ST_WAIT) timer <= timer + 20'd1;

      if (do_grant) begin
        spi_d     <= d[8*grant +: 8];
        spi_speed <= speed[grant];
        owner_r   <= grant;
        spi_req   <= ~spi_req;
        timer     <= '0;
      end

      if (do_done) begin
        q[8*owner_r +: 8] <= spi_q;
        ack[owner_r]      <= ~ack[owner_r];
        rr_ptr            <= next_ptr;
      end

      // Watchdog: complete the byte with 0xFF and drop the engine's half toggle.
      if (do_expire) begin
        q[8*owner_r +: 8] <= 8'hFF;
        ack[owner_r]      <= ~ack[owner_r];
        spi_req           <= spi_ack;
        timeout_err       <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_port_arbiter.sv
// tb/tb_spi_port_arbiter.sv - directed self-checking bench for spi_port_arbiter
module tb_spi_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0, hold = '0, speed = '0, ack;
  logic [15:0] d = '0, q;
  logic        spi_req, spi_speed, busy, timeout_err;
  logic        err_clr = 1'b0;
  logic [7:0]  spi_d;
  logic [2:0]  owner;

  logic        eng_ack = 1'b1;
  logic [7:0]  eng_q = 8'h00, eng_rx = 8'hA5, eng_last_d = 8'h00;
  logic        eng_last_speed = 1'b0;
  bit          eng_en = 1'b1;
  int          eng_delay = 4, eng_cnt = 0;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  spi_port_arbiter #(.CHANNELS(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .hold(hold), .d(d), .speed(speed),
    .q(q), .spi_req(spi_req), .spi_ack(eng_ack), .spi_d(spi_d), .spi_speed(spi_speed),
    .spi_q(eng_q), .owner(owner), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // Behavioural engine: completes a byte eng_delay cycles after seeing a toggle.
  always @(negedge clk) begin
    if (eng_en && reset_n && spi_req !== eng_ack) begin
      if (eng_cnt == 0) begin
        eng_last_d     = spi_d;
        eng_last_speed = spi_speed;
      end
      eng_cnt++;
      if (eng_cnt >= eng_delay) begin
        eng_ack = spi_req;
        eng_q   = eng_rx;
        eng_cnt = 0;
      end
    end else begin
      eng_cnt = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input int ch, input logic [7:0] data);
    d[8*ch +: 8] = data;
    req[ch] = ~req[ch];
  endtask

  task automatic wait_ack(input int ch, input int budget, output bit ok);
    int cyc = 0;
    while (ack[ch] !== req[ch] && cyc < budget) begin
      tick();
      cyc++;
    end
    ok = (ack[ch] === req[ch]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; hold = '0; d = '0; speed = '0; err_clr = 1'b0; eng_ack = 1'b1;
    tick(2);
    n_checks++; if ({ack, q, spi_req, spi_d, spi_speed, owner, busy, timeout_err} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {ack, q, spi_req, spi_d, spi_speed, owner, busy, timeout_err}); end
    reset_n = 1'b1;
    tick();
    n_checks++; if (spi_req !== 1'b1) begin n_fail++; $display("FAIL resync_spi_req: got %b expected 1", spi_req); end
    tick(3);
    n_checks++; if (ack !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL no_spurious_ack: ack %b busy %b expected 00 0", ack, busy); end
  endtask

  task automatic test_single_byte();
    bit ok;
    eng_rx = 8'hA5;
    issue(0, 8'h9F);
    tick();
    n_checks++; if (spi_d !== 8'h9F) begin n_fail++; $display("FAIL single_spi_d: got %h expected 9f", spi_d); end
    n_checks++; if (spi_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: spi_req %b busy %b expected 0 1", spi_req, busy); end
    wait_ack(0, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_ack: got %b expected %b", ack[0], req[0]); end
    n_checks++; if (q[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_q: got %h expected a5", q[7:0]); end
    n_checks++; if (ack[1] !== 1'b0) begin n_fail++; $display("FAIL single_ack1_quiet: got %b expected 0", ack[1]); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] prev;
    int cyc;
    // ch1 alone leaves rr_ptr at 0
    issue(1, 8'h11);
    wait_ack(1, 40, ok);
    tick();
    issue(0, 8'h21); issue(1, 8'h22);
    prev = ack; cyc = 0;
    while (ack === prev && cyc < 40) begin tick(); cyc++; end
    n_checks++; if ((ack ^ prev) !== 2'b01) begin n_fail++; $display("FAIL rr_ptr0_first: got %b expected 01", ack ^ prev); end
    wait_ack(1, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_ptr0_second: got %b expected %b", ack[1], req[1]); end
    // ch0 alone leaves rr_ptr at 1
    tick();
    issue(0, 8'h23);
    wait_ack(0, 40, ok);
    tick();
    issue(0, 8'h24); issue(1, 8'h25);
    prev = ack; cyc = 0;
    while (ack === prev && cyc < 40) begin tick(); cyc++; end
    n_checks++; if ((ack ^ prev) !== 2'b10) begin n_fail++; $display("FAIL rr_ptr1_first: got %b expected 10", ack ^ prev); end
    wait_ack(0, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_ptr1_second: got %b expected %b", ack[0], req[0]); end
    tick();
  endtask

  task automatic test_hold_lock();
    bit ok;
    hold[1] = 1'b1;
    issue(1, 8'h30);
    tick();
    n_checks++; if (owner !== 3'd1) begin n_fail++; $display("FAIL hold_owner: got %0d expected 1", owner); end
    issue(0, 8'h40);
    for (int b = 0; b < 6; b++) begin
      wait_ack(1, 40, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_byte%0d_ack: got %b expected %b", b, ack[1], req[1]); end
      n_checks++; if (ack[0] === req[0]) begin n_fail++; $display("FAIL hold_byte%0d_ch0_blocked: ack0 %b expected %b", b, ack[0], ~req[0]); end
      if (b < 5) issue(1, 8'h31 + 8'(b));
    end
    hold[1] = 1'b0;
    tick();
    n_checks++; if (owner !== 3'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_release_grant: owner %0d busy %b expected 0 1", owner, busy); end
    wait_ack(0, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_release_ack: got %b expected %b", ack[0], req[0]); end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    eng_en = 0;
    issue(0, 8'h55);
    tick();
    tick(15);
    n_checks++; if (ack[0] === req[0] || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: ack0 %b busy %b expected %b 1", ack[0], busy, ~req[0]); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (ack[0] !== req[0]) begin n_fail++; $display("FAIL timeout_ack: got %b expected %b", ack[0], req[0]); end
    n_checks++; if (q[7:0] !== 8'hFF) begin n_fail++; $display("FAIL timeout_q: got %h expected ff", q[7:0]); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_set_wins: got %b expected 1", timeout_err); end
    n_checks++; if (spi_req !== eng_ack) begin n_fail++; $display("FAIL timeout_resync: got %b expected %b", spi_req, eng_ack); end
    eng_en = 1; eng_rx = 8'h3C;
    issue(1, 8'h66);
    wait_ack(1, 40, ok);
    n_checks++; if (!ok || q[15:8] !== 8'h3C) begin n_fail++; $display("FAIL timeout_recover: ok %b q1 %h expected 1 3c", ok, q[15:8]); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b expected 0", timeout_err); end
    tick();
  endtask

  task automatic test_async_reset();
    bit ok;
    eng_en = 0;
    issue(0, 8'h77);
    tick(3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre_busy: got %b expected 1", busy); end
    #2;
    reset_n = 1'b0; req = '0;
    #1;
    n_checks++; if ({ack, q, spi_req, spi_d, spi_speed, owner, busy, timeout_err} !== '0) begin n_fail++; $display("FAIL areset_outputs: got %h expected 0", {ack, q, spi_req, spi_d, spi_speed, owner, busy, timeout_err}); end
    eng_ack = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick();
    n_checks++; if (spi_req !== 1'b1 || ack !== 2'b00) begin n_fail++; $display("FAIL areset_resync: spi_req %b ack %b expected 1 00", spi_req, ack); end
    eng_en = 1; eng_rx = 8'hC3;
    issue(0, 8'h88);
    wait_ack(0, 40, ok);
    n_checks++; if (!ok || q[7:0] !== 8'hC3 || eng_last_d !== 8'h88) begin n_fail++; $display("FAIL areset_byte: ok %b q0 %h tx %h expected 1 c3 88", ok, q[7:0], eng_last_d); end
    tick();
  endtask

  task automatic test_speed();
    bit ok;
    int ch;
    speed = 2'b10;
    for (int i = 0; i < 4; i++) begin
      ch = i % 2;
      issue(ch, 8'hA0 + 8'(i));
      tick();
      n_checks++; if (spi_speed !== (ch == 1) || owner !== 3'(ch)) begin n_fail++; $display("FAIL speed_byte%0d: spi_speed %b owner %0d expected %b %0d", i, spi_speed, owner, ch == 1, ch); end
      wait_ack(ch, 40, ok);
      n_checks++; if (!ok || eng_last_speed !== (ch == 1)) begin n_fail++; $display("FAIL speed_byte%0d_engine: ok %b speed %b expected 1 %b", i, ok, eng_last_speed, ch == 1); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_hold_lock();
    test_timeout();
    test_async_reset();
    test_speed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
